// File: rtl/fpga_keypad.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, debounces
// single-key presses and releases, and shifts each accepted key code into an 8-digit entry register.
module fpga_keypad #(
    parameter int DIV = 5000,
    parameter int DEB = 4
) (
    input  logic        clkx,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down,
    output logic [31:0] value
);

    localparam int TW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [3:0]    DEB_C     = 4'(DEB);

    localparam logic [1:0] S_SCAN     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_HELD     = 2'd2;

    // Row lines are asynchronous to clkx; only the second synchronizer stage is ever decoded.
    logic [3:0]    sync1_q;
    logic [3:0]    rs_q;

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]    ci_q, ci_d;
    logic [1:0]    state_q, state_d;
    logic [3:0]    snap_q, snap_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    rel_q, rel_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_down_q, key_down_d;
    logic [31:0]   value_q, value_d;

    logic          tick;
    logic          accept;
    logic [3:0]    accept_pat;

    function automatic logic one_zero(input logic [3:0] p);
        logic [3:0] z;
        z = ~p;
        return (z != 4'd0) && ((z & (z - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] zero_index(input logic [3:0] p);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!p[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    assign tick = (tick_cnt_q == TICK_LAST);

    always_comb begin
        // NOTE: every variable gets a default up front so no path through the case infers a latch.
        tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
        ci_d        = ci_q;
        state_d     = state_q;
        snap_d      = snap_q;
        cnt_d       = cnt_q;
        rel_d       = rel_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        value_d     = value_q;
        accept      = 1'b0;
        accept_pat  = 4'hF;

        case (state_q)
            S_SCAN: begin
                if (tick) begin
                    if (one_zero(rs_q)) begin
                        snap_d = rs_q;
                        if (DEB_C == 4'd1) begin
                            accept     = 1'b1;
                            accept_pat = rs_q;
                        end else begin
                            cnt_d   = 4'd1;
                            state_d = S_DEBOUNCE;
                        end
                    end else begin
                        // Idle rows and multi-key patterns both move on to the next column.
                        ci_d = ci_q + 2'd1;
                    end
                end
            end
            S_DEBOUNCE: begin
                if (tick) begin
                    if (rs_q == snap_q) begin
                        if ((cnt_q + 4'd1) == DEB_C) begin
                            accept     = 1'b1;
                            accept_pat = snap_q;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = S_SCAN;
                        ci_d    = ci_q + 2'd1;
                    end
                end
            end
            S_HELD: begin
                if (tick) begin
                    if (rs_q == 4'hF) begin
                        if ((rel_q + 4'd1) == DEB_C) begin
                            rel_d      = 4'd0;
                            key_down_d = 1'b0;
                            state_d    = S_SCAN;
                            ci_d       = ci_q + 2'd1;
                        end else begin
                            rel_d = rel_q + 4'd1;
                        end
                    end else begin
                        rel_d = 4'd0;
                    end
                end
            end
            default: state_d = S_SCAN;
        endcase

        // The column index is still the one being driven, so it forms the low two code bits.
        if (accept) begin
            key_code_d  = {zero_index(accept_pat), ci_q};
            value_d     = {value_q[27:0], key_code_d};
            key_valid_d = 1'b1;
            key_down_d  = 1'b1;
            cnt_d       = 4'd0;
            rel_d       = 4'd0;
            state_d     = S_HELD;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clkx or posedge rst) begin
        if (rst) begin
            sync1_q     <= 4'hF;
            rs_q        <= 4'hF;
            tick_cnt_q  <= '0;
            ci_q        <= 2'd0;
            state_q     <= S_SCAN;
            snap_q      <= 4'hF;
            cnt_q       <= 4'd0;
            rel_q       <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            value_q     <= 32'd0;
        end else begin
            sync1_q     <= row;
            rs_q        <= sync1_q;
            tick_cnt_q  <= tick_cnt_d;
            ci_q        <= ci_d;
            state_q     <= state_d;
            snap_q      <= snap_d;
            cnt_q       <= cnt_d;
            rel_q       <= rel_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
            value_q     <= value_d;
        end
    end

    assign col       = ~(4'b0001 << ci_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;
    assign value     = value_q;

endmodule

// File: tb/tb_fpga_keypad.sv
// Bench for fpga_keypad with DIV=4, DEB=2: a keypad model drives the rows from the
// scanned columns, and a scoreboard monitor checks every key_valid pulse.
module tb_fpga_keypad;

    localparam int DIV = 4;
    localparam int DEB = 2;

    logic        clkx = 1'b0;
    logic        rst  = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [31:0] value;

    logic        key_on  = 1'b0;
    int          key_r   = 0;
    int          key_c   = 0;
    logic        ovr_en  = 1'b0;
    logic [3:0]  ovr_val = 4'hF;

    int total  = 0;
    int bad    = 0;
    int pulses = 0;

    typedef struct packed {
        logic [3:0]  code;
        logic [31:0] value;
    } exp_t;
    exp_t exp_q[$];

    fpga_keypad #(.DIV(DIV), .DEB(DEB)) dut (
        .clkx      (clkx),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down),
        .value     (value)
    );

    always #5 clkx = ~clkx;

    // Keypad: a held key pulls its row low whenever its column is driven low.
    assign row = ovr_en ? ovr_val :
                 (key_on && (col[key_c] == 1'b0)) ? ~(4'b0001 << key_r) : 4'hF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clkx) begin
        if (key_valid === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got code %h value %h, want no pulse", key_code, value);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_code", {28'd0, key_code}, {28'd0, e.code});
                check("pulse_value", value, e.value);
                check("pulse_key_down", {31'd0, key_down}, 32'd1);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clkx);
    endtask

    task automatic wait_col_step(output int cyc);
        logic [3:0] prev;
        prev = col;
        cyc  = 0;
        while (col === prev && cyc < 40) begin
            @(negedge clkx);
            cyc++;
        end
        if (col === prev) begin
            total++;
            bad++;
            $display("FAIL col_step_timeout: got col %b unchanged for %0d cycles, want a step", col, cyc);
        end
    endtask

    task automatic wait_pulses(input int n);
        int k;
        k = 0;
        while (pulses < n && k < 200) begin
            @(negedge clkx);
            k++;
        end
        check("pulse_count", pulses, n);
    endtask

    task automatic press(input int r, input int c, input logic [31:0] exp_value);
        exp_t e;
        e.code  = 4'(4 * r + c);
        e.value = exp_value;
        exp_q.push_back(e);
        key_r  = r;
        key_c  = c;
        key_on = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq [4];
        int cyc;
        int k;
        seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

        // Reset state
        cycles(3);
        check("rst_col", {28'd0, col}, 32'hE);
        check("rst_key_code", {28'd0, key_code}, 32'd0);
        check("rst_key_valid", {31'd0, key_valid}, 32'd0);
        check("rst_key_down", {31'd0, key_down}, 32'd0);
        check("rst_value", value, 32'd0);
        rst = 1'b0;

        // Idle scan: one column step every DIV cycles
        for (int i = 0; i < 4; i++) begin
            wait_col_step(cyc);
            check("scan_col", {28'd0, col}, {28'd0, seq[i]});
            if (i > 0) check("scan_period", cyc, DIV);
        end

        // Key 6 (row 1, column 2), held 20 ticks without repeating
        press(1, 2, 32'h0000_0006);
        wait_pulses(1);
        check("held_key_down", {31'd0, key_down}, 32'd1);
        check("held_col", {28'd0, col}, 32'hB);
        cycles(20 * DIV);
        check("held_long_key_down", {31'd0, key_down}, 32'd1);
        check("held_long_col", {28'd0, col}, 32'hB);
        check("held_no_repeat", pulses, 1);
        key_on = 1'b0;
        cycles(16);
        check("release_key_down", {31'd0, key_down}, 32'd0);

        // Key F (row 3, column 3)
        press(3, 3, 32'h0000_006F);
        wait_pulses(2);
        check("second_value", value, 32'h0000_006F);
        key_on = 1'b0;
        cycles(16);
        check("second_release", {31'd0, key_down}, 32'd0);

        // One-tick glitch: debounce aborts, scanning resumes
        wait_col_step(cyc);
        ovr_val = 4'b1110;
        ovr_en  = 1'b1;
        cycles(DIV);
        ovr_en  = 1'b0;
        cycles(12);
        check("glitch_no_pulse", pulses, 2);
        wait_col_step(cyc);

        // Two keys in one column are ignored and the scan keeps stepping
        ovr_val = 4'b1100;
        ovr_en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_col_step(cyc);
            check("dual_period", cyc, DIV);
        end
        ovr_en = 1'b0;
        check("dual_no_pulse", pulses, 2);

        // Reset during debounce: no pulse, value cleared immediately
        key_r  = 2;
        key_c  = 1;
        key_on = 1'b1;
        k = 0;
        do begin
            wait_col_step(cyc);
            k++;
        end while (col !== 4'b1101 && k < 8);
        cycles(6);
        #1 rst = 1'b1;
        #1;
        check("deb_rst_col", {28'd0, col}, 32'hE);
        check("deb_rst_value", value, 32'd0);
        check("deb_rst_key_valid", {31'd0, key_valid}, 32'd0);
        key_on = 1'b0;
        cycles(3);
        rst = 1'b0;
        wait_col_step(cyc);
        check("resume_ci0", {28'd0, col}, 32'hD);
        cycles(20);
        check("deb_rst_no_pulse", pulses, 2);

        // Reset while held
        press(2, 3, 32'h0000_000B);
        wait_pulses(3);
        cycles(8);
        check("held2_key_down", {31'd0, key_down}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("held_rst_key_down", {31'd0, key_down}, 32'd0);
        check("held_rst_value", value, 32'd0);
        check("held_rst_col", {28'd0, col}, 32'hE);
        check("held_rst_key_code", {28'd0, key_code}, 32'd0);
        key_on = 1'b0;
        cycles(2);
        rst = 1'b0;
        cycles(20);
        check("final_pulses", pulses, 3);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpga_keypad.md
FPGA_KEYPAD -- requirements
Module: fpga_keypad

Interface
REQ-001 Parameter DIV, default 5000, sets the scan-tick period in clkx cycles (legal range 2 and up).
REQ-002 Parameter DEB, default 4, sets the consecutive stable scan ticks needed to accept a press or a release (legal range 1 to 15).
REQ-003 clkx  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 row  input  4  keypad row lines; active-low; pulled up; asynchronous to clkx.
REQ-006 col  output  4  keypad column drive; active-low; exactly one bit low at all times.
REQ-007 key_code  output  4  code of the last accepted key.
REQ-008 key_valid  output  1  one-clkx-cycle pulse per accepted key press.
REQ-009 key_down  output  1  high while an accepted key is still held.
REQ-010 value  output  32  8-hex-digit entry register, ready to drive an 8-digit display.

Function
REQ-011 row SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rs).
REQ-012 Tick counter SHALL count 0..DIV-1 and wrap to 0; tick is high for one cycle when the count equals DIV-1.
REQ-013 Column index ci (2 bits) SHALL drive col = ~(4'b0001 << ci).
REQ-014 The FSM SHALL have three states: SCAN, DEBOUNCE, HELD; it changes state only on tick cycles.
REQ-015 SCAN, on tick, rs == 4'b1111: ci SHALL advance by 1 mod 4.
REQ-016 SCAN, on tick, rs has exactly one zero: snap <= rs, cnt <= 1, state -> DEBOUNCE, ci held.
REQ-017 SCAN, on tick, rs has two or more zeros: the pattern SHALL be ignored and ci SHALL advance.
REQ-018 DEBOUNCE, on tick, rs == snap: cnt SHALL increment.
REQ-019 DEBOUNCE, on tick, rs != snap: state -> SCAN, ci SHALL advance, no output.
REQ-020 DEBOUNCE with DEB == 1: the press is accepted at the SCAN tick itself (no DEBOUNCE dwell).
REQ-021 Acceptance occurs when cnt reaches DEB. On that same clkx edge: key_code <= 4*r + ci (r = index of the zero bit in snap); value <= {value[27:0], code}; key_valid = 1 for exactly that cycle; key_down <= 1; state -> HELD.
REQ-022 HELD: ci held; no further key_valid (no auto-repeat).
REQ-023 HELD, on tick, rs == 4'b1111: release count increments.
REQ-024 HELD, on tick, rs != 4'b1111: release count clears.
REQ-025 HELD, release count reaches DEB: key_down <= 0, state -> SCAN, ci advances.
REQ-026 key_code and value SHALL hold their values between accepted presses.
REQ-027 value SHALL shift modulo 32 bits; the oldest digit is discarded.

Reset
REQ-028 While rst is high, the block SHALL asynchronously force:
- col = 4'b1110 (ci = 0)
- key_code = 0, key_valid = 0, key_down = 0, value = 0
- state = SCAN; tick, debounce and release counters = 0; synchronizer flops = 4'b1111.
REQ-029 Reset asserted in DEBOUNCE or HELD SHALL abort the operation with no key_valid pulse.
REQ-030 After rst deasserts, scanning SHALL resume from ci = 0.

Verification (DIV=4, DEB=2)
REQ-031 Assert rst mid-run -> col = 1110, value = 0, key_valid = 0 immediately, before the next clock edge.
REQ-032 row = 1111 constant -> col steps 1110, 1101, 1011, 0111, 1110, one step every 4 clkx cycles.
REQ-033 Hold row = 1101 while ci = 2 for 3 or more ticks -> one key_valid pulse, key_code = 6, value = 0x00000006, key_down = 1.
REQ-034 row low for 1 tick, then 1111 -> no key_valid; scanning resumes.
REQ-035 Hold key 6 for 20 ticks, release for 2 or more ticks, then press row = 0111 at ci = 3:
- exactly two key_valid pulses in total
- value = 0x0000006F.
REQ-036 row = 1100 (two keys in one column) -> no key_valid. Assert rst while in HELD -> key_down = 0 and value = 0.
